risc_control_unit: RTL and testbench
====================================

Name: risc_control_unit

Overview:
- Moore/Mealy FSM that sequences the RISC datapath: PC, IR, address register, R0–R3, Reg_Y, Reg_Z (zero-flag flop) and memory write.
- Runs fetch/decode/execute.
- Drives every register load enable and both bus mux selects.
- Sits beside the datapath; the ALU decodes its own operation from IR[7:4].

Parameters:
- WORD_SIZE, 8, instruction/data width.
- OP_SIZE, 4, opcode field width (IR[7:4]).
- SEL1_SIZE, 3, bus_1 select width.
- SEL2_SIZE, 2, bus_2 select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  WORD_SIZE  IR contents; [7:4] opcode, [3:2] src, [1:0] dest.
- zero  in  1  Reg_Z zero-flag flop output.
- load_reg  out  4  one-hot load enable for R0..R3.
- load_PC  out  1  PC load from bus_2.
- inc_PC  out  1  PC increment.
- load_IR  out  1  IR load from bus_2.
- load_Add_R  out  1  address register load from bus_2.
- load_Reg_Y  out  1  Reg_Y load from bus_2.
- load_Reg_Z  out  1  zero-flag load.
- sel_bus_1  out  3  0–3 = R0–R3, 4 = PC.
- sel_bus_2  out  2  0 = ALU, 1 = bus_1, 2 = memory.
- write  out  1  memory write strobe.
- halted  out  1  high in S_halt.

Behaviour:
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Values 9–15 are illegal.
- rst high: state forced to S_idle asynchronously. All outputs are 0 while rst is asserted and in S_idle. Reset mid-instruction abandons it; no partial write is issued after rst rises.
- Outputs are combinational from state, IR and zero. Unlisted outputs are 0 in every state.
- S_idle: -> S_fet1.
- S_fet1: sel_bus_1=4, sel_bus_2=1, load_Add_R. -> S_fet2.
- S_fet2: sel_bus_2=2, load_IR, inc_PC. -> S_dec.
- S_dec, by opcode:
  - NOP: -> S_fet1.
  - ADD/SUB/AND: sel_bus_1=src, sel_bus_2=1, load_Reg_Y. -> S_ex1.
  - NOT: sel_bus_1=src, sel_bus_2=0, load_Reg_Z, load_reg[dest]. -> S_fet1.
  - RD: sel_bus_1=4, sel_bus_2=1, load_Add_R. -> S_rd1.
  - WR: same as RD. -> S_wr1.
  - BR: same as RD. -> S_br1.
  - BRZ, zero=1: same as RD. -> S_br1.
  - BRZ, zero=0: inc_PC (skip operand). -> S_fet1.
  - Illegal: -> S_halt.
- S_ex1: sel_bus_1=dest, sel_bus_2=0, load_Reg_Z, load_reg[dest]. -> S_fet1.
- S_rd1: sel_bus_2=2, load_Add_R, inc_PC. -> S_rd2.
- S_rd2: sel_bus_2=2, load_reg[dest]. -> S_fet1.
- S_wr1: sel_bus_2=2, load_Add_R, inc_PC. -> S_wr2.
- S_wr2: sel_bus_1=src, write. -> S_fet1.
- S_br1: sel_bus_2=2, load_Add_R. -> S_br2.
- S_br2: sel_bus_2=2, load_PC. -> S_fet1.
- S_halt: halted=1, all loads 0. Exited only by rst.
- Instruction latency in clocks, fetch included:
  - NOP 3; NOT 3; ADD/SUB/AND 4.
  - RD/WR 5; BR 5.
  - BRZ 5 if taken, 3 if not taken.
- zero is sampled only in S_dec.
- At most one load_reg bit is ever high.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input step (1 bit) and state S_wait.
  - Every transition that would enter S_fet1 goes to S_wait instead. This includes S_idle.
  - S_wait drives all outputs 0. It leaves to S_fet1 on the first cycle step=1; step held high advances one instruction per S_wait visit.
  - rst still returns the FSM to S_idle.
- Undefined: no step port, no S_wait, free-running sequencing.

Decomposition:
- Package risc_ctrl_pkg holds:
  - opcode constants;
  - state encoding (4-bit, S_idle=0);
  - sel_bus_1/sel_bus_2 encodings;
  - field-position constants for IR.
- Sub-module risc_instr_decode (combinational) splits IR into opcode/src/dest and flags illegal opcodes. The FSM instantiates it once.

Test Plan:
- rst pulse mid-S_wr2 (IR=0x6E) -> all outputs 0 immediately, write never reasserts. After release: S_idle then S_fet1 with load_Add_R=1, sel_bus_1=4.
- IR=0x16 (ADD R1,R2) -> S_dec: sel_bus_1=1, load_Reg_Y. S_ex1: sel_bus_1=2, sel_bus_2=0, load_reg=4'b0100, load_Reg_Z. Back to S_fet1 on the 5th clock from fetch start.
- IR=0x53 (RD ->R3) -> rd1: inc_PC with sel_bus_2=2. rd2: load_reg=4'b1000. No write at any point.
- IR=0x80 with zero=0 -> inc_PC in S_dec, S_fet1 next. Repeat with zero=1 -> S_br1, then S_br2 with load_PC=1.
- IR=0xF0 -> S_halt, halted=1 held for 20 clocks with all loads 0. rst then clears halted.
- SINGLE_STEP_EN, IR=0x00, step low 10 cycles -> FSM stays in S_wait. One-cycle step pulse -> exactly one NOP executed, returns to S_wait.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : risc_ctrl_pkg
// Description : Shared definitions for the RISC control unit: opcode values,
//               FSM state encoding, bus-select encodings and the bit positions
//               of the fields inside the instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_ctrl_pkg;

    // ------------------------------------------------------------------------
    // Opcodes carried in IR[7:4]; anything above OP_BRZ is illegal.
    // ------------------------------------------------------------------------
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    // ------------------------------------------------------------------------
    // FSM states. S_WAIT is only reachable in single-step builds.
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11,
        S_WAIT = 4'd12
    } state_t;

    // ------------------------------------------------------------------------
    // Bus select encodings. bus_1 values 0..3 pick R0..R3 directly.
    // ------------------------------------------------------------------------
    localparam logic [2:0] SEL1_PC   = 3'd4;
    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    // ------------------------------------------------------------------------
    // Instruction register field positions.
    // ------------------------------------------------------------------------
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;
    localparam int SRC_MSB  = 3;
    localparam int SRC_LSB  = 2;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

    // One-hot register load vector for a 2-bit register index.
    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : risc_ctrl_pkg
`default_nettype wire

// File: rtl/risc_instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : risc_instr_decode
// Description : Purely combinational split of the instruction register into
//               opcode, source and destination register fields, plus a flag
//               for opcodes outside the defined instruction set.
// Ports       : instruction [WORD_SIZE-1:0] in  - IR contents
//               opcode      [OP_SIZE-1:0]   out - IR[7:4]
//               src         [1:0]           out - IR[3:2]
//               dest        [1:0]           out - IR[1:0]
//               illegal                     out - opcode not in NOP..BRZ
// Revision    : 1.0 - initial release
// ============================================================================
module risc_instr_decode
    import risc_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4
) (
    input  logic [WORD_SIZE-1:0] instruction,
    output logic [OP_SIZE-1:0]   opcode,
    output logic [1:0]           src,
    output logic [1:0]           dest,
    output logic                 illegal
);

    assign opcode  = instruction[OP_MSB:OP_LSB];
    assign src     = instruction[SRC_MSB:SRC_LSB];
    assign dest    = instruction[DEST_MSB:DEST_LSB];

    // Opcodes are dense from NOP up to BRZ, so one magnitude compare suffices.
    assign illegal = (opcode > OP_SIZE'(OP_BRZ));

endmodule : risc_instr_decode
`default_nettype wire

// File: rtl/risc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : risc_control_unit
// Description : Fetch/decode/execute sequencer for the 8-bit RISC datapath.
//               Drives every register load enable, the PC increment, the two
//               bus multiplexer selects and the memory write strobe. Outputs
//               are decoded combinationally from state, IR and the zero flag.
//               Optional build macro SINGLE_STEP_EN adds a 'step' input and a
//               wait state in front of every instruction fetch.
// Ports       : clk          in  - clock, rising edge
//               rst          in  - asynchronous active-high reset
//               instruction  in  - IR contents [7:4] op, [3:2] src, [1:0] dest
//               zero         in  - zero-flag flop output
//               step         in  - (SINGLE_STEP_EN only) advance one instr
//               load_reg     out - one-hot load for R0..R3
//               load_PC      out - PC load from bus_2
//               inc_PC       out - PC increment
//               load_IR      out - IR load from bus_2
//               load_Add_R   out - address register load from bus_2
//               load_Reg_Y   out - Reg_Y load from bus_2
//               load_Reg_Z   out - zero-flag load
//               sel_bus_1    out - 0..3 = R0..R3, 4 = PC
//               sel_bus_2    out - 0 = ALU, 1 = bus_1, 2 = memory
//               write        out - memory write strobe
//               halted       out - high while halted on an illegal opcode
// Revision    : 1.0 - initial release
// ============================================================================
module risc_control_unit
    import risc_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4,
    parameter int SEL1_SIZE = 3,
    parameter int SEL2_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic                 zero,
`ifdef SINGLE_STEP_EN
    input  logic                 step,
`endif
    output logic [3:0]           load_reg,
    output logic                 load_PC,
    output logic                 inc_PC,
    output logic                 load_IR,
    output logic                 load_Add_R,
    output logic                 load_Reg_Y,
    output logic                 load_Reg_Z,
    output logic [SEL1_SIZE-1:0] sel_bus_1,
    output logic [SEL2_SIZE-1:0] sel_bus_2,
    output logic                 write,
    output logic                 halted
);

    // Every path that starts a new instruction goes through this state, so
    // single-step builds only need to redirect it to the wait state.
`ifdef SINGLE_STEP_EN
    localparam state_t FETCH_ENTRY = S_WAIT;
`else
    localparam state_t FETCH_ENTRY = S_FET1;
`endif

    state_t               state;
    state_t               next_state;

    logic [OP_SIZE-1:0]   opcode;
    logic [1:0]           src;
    logic [1:0]           dest;
    logic                 illegal;

    risc_instr_decode #(
        .WORD_SIZE (WORD_SIZE),
        .OP_SIZE   (OP_SIZE)
    ) u_decode (
        .instruction (instruction),
        .opcode      (opcode),
        .src         (src),
        .dest        (dest),
        .illegal     (illegal)
    );

    // ------------------------------------------------------------------------
    // State register. Reset is asynchronous so a pending memory write is
    // withdrawn the moment rst rises, not at the next clock.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode.
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        load_reg   = 4'b0000;
        load_PC    = 1'b0;
        inc_PC     = 1'b0;
        load_IR    = 1'b0;
        load_Add_R = 1'b0;
        load_Reg_Y = 1'b0;
        load_Reg_Z = 1'b0;
        sel_bus_1  = '0;
        sel_bus_2  = '0;
        write      = 1'b0;
        halted     = 1'b0;

        case (state)
            S_IDLE: begin
                next_state = FETCH_ENTRY;
            end

            // PC -> address register.
            S_FET1: begin
                sel_bus_1  = SEL1_SIZE'(SEL1_PC);
                sel_bus_2  = SEL2_SIZE'(SEL2_BUS1);
                load_Add_R = 1'b1;
                next_state = S_FET2;
            end

            // mem[addr] -> IR, PC now points at the operand or next opcode.
            S_FET2: begin
                sel_bus_2  = SEL2_SIZE'(SEL2_MEM);
                load_IR    = 1'b1;
                inc_PC     = 1'b1;
                next_state = S_DEC;
            end

            S_DEC: begin
                if (illegal) begin
                    next_state = S_HALT;
                end else begin
                    case (opcode)
                        OP_NOP: begin
                            next_state = FETCH_ENTRY;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            // First operand parked in Reg_Y; the second comes
                            // straight off bus_1 during S_EX1.
                            sel_bus_1  = SEL1_SIZE'(src);
                            sel_bus_2  = SEL2_SIZE'(SEL2_BUS1);
                            load_Reg_Y = 1'b1;
                            next_state = S_EX1;
                        end
                        OP_NOT: begin
                            sel_bus_1  = SEL1_SIZE'(src);
                            sel_bus_2  = SEL2_SIZE'(SEL2_ALU);
                            load_Reg_Z = 1'b1;
                            load_reg   = reg_onehot(dest);
                            next_state = FETCH_ENTRY;
                        end
                        OP_RD: begin
                            sel_bus_1  = SEL1_SIZE'(SEL1_PC);
                            sel_bus_2  = SEL2_SIZE'(SEL2_BUS1);
                            load_Add_R = 1'b1;
                            next_state = S_RD1;
                        end
                        OP_WR: begin
                            sel_bus_1  = SEL1_SIZE'(SEL1_PC);
                            sel_bus_2  = SEL2_SIZE'(SEL2_BUS1);
                            load_Add_R = 1'b1;
                            next_state = S_WR1;
                        end
                        OP_BR: begin
                            sel_bus_1  = SEL1_SIZE'(SEL1_PC);
                            sel_bus_2  = SEL2_SIZE'(SEL2_BUS1);
                            load_Add_R = 1'b1;
                            next_state = S_BR1;
                        end
                        OP_BRZ: begin
                            if (zero) begin
                                sel_bus_1  = SEL1_SIZE'(SEL1_PC);
                                sel_bus_2  = SEL2_SIZE'(SEL2_BUS1);
                                load_Add_R = 1'b1;
                                next_state = S_BR1;
                            end else begin
                                // Branch not taken: step PC over the target
                                // address word.
                                inc_PC     = 1'b1;
                                next_state = FETCH_ENTRY;
                            end
                        end
                        default: begin
                            next_state = S_HALT;
                        end
                    endcase
                end
            end

            // ALU result written back; the ALU reads Reg_Y and bus_1.
            S_EX1: begin
                sel_bus_1  = SEL1_SIZE'(dest);
                sel_bus_2  = SEL2_SIZE'(SEL2_ALU);
                load_Reg_Z = 1'b1;
                load_reg   = reg_onehot(dest);
                next_state = FETCH_ENTRY;
            end

            // Operand word (data address) -> address register.
            S_RD1: begin
                sel_bus_2  = SEL2_SIZE'(SEL2_MEM);
                load_Add_R = 1'b1;
                inc_PC     = 1'b1;
                next_state = S_RD2;
            end

            S_RD2: begin
                sel_bus_2  = SEL2_SIZE'(SEL2_MEM);
                load_reg   = reg_onehot(dest);
                next_state = FETCH_ENTRY;
            end

            S_WR1: begin
                sel_bus_2  = SEL2_SIZE'(SEL2_MEM);
                load_Add_R = 1'b1;
                inc_PC     = 1'b1;
                next_state = S_WR2;
            end

            S_WR2: begin
                sel_bus_1  = SEL1_SIZE'(src);
                write      = 1'b1;
                next_state = FETCH_ENTRY;
            end

            // Branch target word -> address register, then mem -> PC.
            S_BR1: begin
                sel_bus_2  = SEL2_SIZE'(SEL2_MEM);
                load_Add_R = 1'b1;
                next_state = S_BR2;
            end

            S_BR2: begin
                sel_bus_2  = SEL2_SIZE'(SEL2_MEM);
                load_PC    = 1'b1;
                next_state = FETCH_ENTRY;
            end

            // Only rst leaves this state.
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end

`ifdef SINGLE_STEP_EN
            S_WAIT: begin
                if (step) begin
                    next_state = S_FET1;
                end
            end
`endif

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule : risc_control_unit
`default_nettype wire

// File: tb/tb_risc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_control_unit
// Description : Self-checking bench for risc_control_unit. A table of hand
//               written instruction vectors, hand sequences for reset during
//               a write, halt and single-step, and random instruction streams
//               checked against a per-instruction micro-operation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_control_unit;

    typedef struct packed {
        logic [3:0] load_reg;
        logic       load_PC;
        logic       inc_PC;
        logic       load_IR;
        logic       load_Add_R;
        logic       load_Reg_Y;
        logic       load_Reg_Z;
        logic [2:0] sel1;
        logic [1:0] sel2;
        logic       write;
        logic       halted;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    dec;
    } cyc_t;

    typedef struct {
        logic [7:0] ins;
        logic       z;
        int         lat;
        outs_t      dec_o;
        outs_t      last_o;
    } vec_t;

`ifdef SINGLE_STEP_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       zero;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif
    logic [3:0] load_reg;
    logic       load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic       write, halted;

    outs_t act;
    assign act = {load_reg, load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y,
                  load_Reg_Z, sel_bus_1, sel_bus_2, write, halted};

    int checks   = 0;
    int failures = 0;
    cyc_t trace[$];
    vec_t vec[$];

    always #5 clk = ~clk;

    risc_control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .zero        (zero),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .load_reg    (load_reg),
        .load_PC     (load_PC),
        .inc_PC      (inc_PC),
        .load_IR     (load_IR),
        .load_Add_R  (load_Add_R),
        .load_Reg_Y  (load_Reg_Y),
        .load_Reg_Z  (load_Reg_Z),
        .sel_bus_1   (sel_bus_1),
        .sel_bus_2   (sel_bus_2),
        .write       (write),
        .halted      (halted)
    );

    function automatic outs_t mk(input logic [3:0] lr, input logic pc, inc, ir, ar, y, z,
                                 input logic [2:0] s1, input logic [1:0] s2,
                                 input logic w, h);
        outs_t o;
        o.load_reg = lr;  o.load_PC = pc;    o.inc_PC = inc;   o.load_IR = ir;
        o.load_Add_R = ar; o.load_Reg_Y = y; o.load_Reg_Z = z;
        o.sel1 = s1; o.sel2 = s2; o.write = w; o.halted = h;
        return o;
    endfunction

    // Micro-operations shared by several instructions.
    function automatic outs_t u_pc_to_ar();   return mk(4'h0,0,0,0,1,0,0,3'd4,2'd1,0,0); endfunction
    function automatic outs_t u_fetch_ir();   return mk(4'h0,0,1,1,0,0,0,3'd0,2'd2,0,0); endfunction
    function automatic outs_t u_mem_ar_inc(); return mk(4'h0,0,1,0,1,0,0,3'd0,2'd2,0,0); endfunction
    function automatic outs_t u_halt();       return mk(4'h0,0,0,0,0,0,0,3'd0,2'd0,0,1); endfunction

    task automatic check(input string name, input outs_t a, input outs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, a, e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input outs_t o);
        trace.push_back('{o: o, dec: 1'b0});
    endtask

    // Expected per-cycle outputs for one instruction, from its first cycle
    // (wait state in single-step builds, else fetch) to its last.
    task automatic build_trace(input logic [7:0] ins, input logic z);
        logic [3:0] op;
        logic [1:0] s, d;
        logic [3:0] oh;
        op = ins[7:4]; s = ins[3:2]; d = ins[1:0];
        oh = 4'b0001 << d;
        trace.delete();
`ifdef SINGLE_STEP_EN
        push('0);
`endif
        push(u_pc_to_ar());
        push(u_fetch_ir());
        if (op == 4'd0) begin
            push('0);
        end else if (op >= 4'd1 && op <= 4'd3) begin
            push(mk(4'h0,0,0,0,0,1,0,{1'b0,s},2'd1,0,0));
            push(mk(oh,  0,0,0,0,0,1,{1'b0,d},2'd0,0,0));
        end else if (op == 4'd4) begin
            push(mk(oh,0,0,0,0,0,1,{1'b0,s},2'd0,0,0));
        end else if (op == 4'd5) begin
            push(u_pc_to_ar());
            push(u_mem_ar_inc());
            push(mk(oh,0,0,0,0,0,0,3'd0,2'd2,0,0));
        end else if (op == 4'd6) begin
            push(u_pc_to_ar());
            push(u_mem_ar_inc());
            push(mk(4'h0,0,0,0,0,0,0,{1'b0,s},2'd0,1,0));
        end else if (op == 4'd7 || (op == 4'd8 && z)) begin
            push(u_pc_to_ar());
            push(mk(4'h0,0,0,0,1,0,0,3'd0,2'd2,0,0));
            push(mk(4'h0,1,0,0,0,0,0,3'd0,2'd2,0,0));
        end else if (op == 4'd8) begin
            push(mk(4'h0,0,1,0,0,0,0,3'd0,2'd0,0,0));
        end else begin
            push('0);
            repeat (20) push(u_halt());
        end
        trace[OFF+2].dec = 1'b1;
    endtask

    task automatic run_trace(input logic [7:0] ins, input logic z);
        build_trace(ins, z);
        foreach (trace[i]) begin
            next_cycle();
            instruction = ins;
            zero = trace[i].dec ? z : 1'($urandom);
`ifdef SINGLE_STEP_EN
            step = 1'b1;
`endif
            #1;
            check($sformatf("rand_ir%h_c%0d", ins, i), act, trace[i].o);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instruction = 8'h00;
        zero = 1'b0;
        @(posedge clk);
        #1;
        check("reset_hold", act, '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_idle", act, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        instruction = 8'h00;
        zero = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
`endif
        // ins, zero, latency, decode-cycle outputs, last-cycle outputs
        vec.push_back('{8'h00, 1'b0, 3, '0, '0});
        vec.push_back('{8'h16, 1'b0, 4, mk(4'h0,0,0,0,0,1,0,3'd1,2'd1,0,0), mk(4'b0100,0,0,0,0,0,1,3'd2,2'd0,0,0)});
        vec.push_back('{8'h2B, 1'b1, 4, mk(4'h0,0,0,0,0,1,0,3'd2,2'd1,0,0), mk(4'b1000,0,0,0,0,0,1,3'd3,2'd0,0,0)});
        vec.push_back('{8'h39, 1'b0, 4, mk(4'h0,0,0,0,0,1,0,3'd2,2'd1,0,0), mk(4'b0010,0,0,0,0,0,1,3'd1,2'd0,0,0)});
        vec.push_back('{8'h47, 1'b1, 3, mk(4'b1000,0,0,0,0,0,1,3'd1,2'd0,0,0), mk(4'b1000,0,0,0,0,0,1,3'd1,2'd0,0,0)});
        vec.push_back('{8'h53, 1'b0, 5, u_pc_to_ar(), mk(4'b1000,0,0,0,0,0,0,3'd0,2'd2,0,0)});
        vec.push_back('{8'h6E, 1'b0, 5, u_pc_to_ar(), mk(4'h0,0,0,0,0,0,0,3'd3,2'd0,1,0)});
        vec.push_back('{8'h70, 1'b0, 5, u_pc_to_ar(), mk(4'h0,1,0,0,0,0,0,3'd0,2'd2,0,0)});
        vec.push_back('{8'h80, 1'b0, 3, mk(4'h0,0,1,0,0,0,0,3'd0,2'd0,0,0), mk(4'h0,0,1,0,0,0,0,3'd0,2'd0,0,0)});
        vec.push_back('{8'h80, 1'b1, 5, u_pc_to_ar(), mk(4'h0,1,0,0,0,0,0,3'd0,2'd2,0,0)});

        // ---------------- table-driven vectors ----------------
        do_reset();
        foreach (vec[t]) begin
            for (int c = 0; c < OFF + vec[t].lat; c++) begin
                next_cycle();
                instruction = vec[t].ins;
                zero = (c == OFF + 2) ? vec[t].z : 1'($urandom);
                #1;
`ifdef SINGLE_STEP_EN
                if (c == 0) check($sformatf("tbl%0d_wait", t), act, '0);
`endif
                if (c == OFF)     check($sformatf("tbl%0d_fet1", t), act, u_pc_to_ar());
                if (c == OFF + 1) check($sformatf("tbl%0d_fet2", t), act, u_fetch_ir());
                if (c == OFF + 2) check($sformatf("tbl%0d_dec", t), act, vec[t].dec_o);
                if (c == OFF + vec[t].lat - 1)
                    check($sformatf("tbl%0d_last", t), act, vec[t].last_o);
            end
        end
        next_cycle();
        #1;
`ifdef SINGLE_STEP_EN
        check("tbl_end_wait", act, '0);
`else
        check("tbl_end_fet1", act, u_pc_to_ar());
`endif

        // ---------------- reset in the middle of S_wr2 ----------------
        do_reset();
        for (int c = 0; c < OFF + 5; c++) begin
            next_cycle();
            instruction = 8'h6E;
            zero = 1'($urandom);
            #1;
        end
        check("wr2_before_rst", act, mk(4'h0,0,0,0,0,0,0,3'd3,2'd0,1,0));
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_clear", act, '0);
        repeat (3) begin
            next_cycle();
            #1;
            check("rst_hold_no_write", act, '0);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        check("rst_release_idle", act, '0);
`ifdef SINGLE_STEP_EN
        next_cycle();
        #1;
        check("rst_release_wait", act, '0);
`endif
        next_cycle();
        #1;
        check("rst_release_fet1", act, u_pc_to_ar());

        // ---------------- illegal opcode halts ----------------
        do_reset();
        for (int c = 0; c < OFF + 3; c++) begin
            next_cycle();
            instruction = 8'hF0;
            zero = 1'($urandom);
            #1;
        end
        check("illegal_dec", act, '0);
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            zero = 1'($urandom);
            #1;
            check($sformatf("halt_c%0d", c), act, u_halt());
        end
        #1;
        rst = 1'b1;
        #1;
        check("halt_rst_clear", act, '0);
        next_cycle();
        rst = 1'b0;

`ifdef SINGLE_STEP_EN
        // ---------------- single-step ----------------
        step = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            check($sformatf("ss_hold_c%0d", c), act, '0);
        end
        next_cycle();
        step = 1'b1;
        #1;
        check("ss_pulse_wait", act, '0);
        next_cycle();
        step = 1'b0;
        #1;
        check("ss_fet1", act, u_pc_to_ar());
        next_cycle();
        #1;
        check("ss_fet2", act, u_fetch_ir());
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            #1;
            check($sformatf("ss_after_c%0d", c), act, '0);
        end
        step = 1'b1;
`endif

        // ---------------- random instruction streams ----------------
        for (int sq = 0; sq < 30; sq++) begin
            int n;
            do_reset();
            n = $urandom_range(3, 8);
            for (int k = 0; k < n; k++) begin
                logic [7:0] ins;
                ins[7:4] = 4'($urandom_range(0, 8));
                ins[3:0] = 4'($urandom);
                run_trace(ins, 1'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                logic [7:0] bad;
                bad[7:4] = 4'($urandom_range(9, 15));
                bad[3:0] = 4'($urandom);
                run_trace(bad, 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_risc_control_unit
`default_nettype wire
